// File: rtl/gnrc_ffs_pkg.sv
// Shared types and helpers for the set-bit iterator (gnrc_ffs_iter) and its
// first-'1' picker.
package gnrc_ffs_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } ffs_state_e;

  // A single-bit vector still needs a one-bit index port.
  function automatic int ffs_cnt_width(input int width);
    return $clog2(width) + ((width == 1) ? 1 : 0);
  endfunction

endpackage

// File: rtl/gnrc_ffs_pick.sv
// Combinational first-'1' picker: finds the next bit to emit from the
// remaining-bits vector in the scan order selected by MODE.
module gnrc_ffs_pick
  import gnrc_ffs_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter bit MODE  = 1'b0,
  localparam int CNT_WIDTH = ffs_cnt_width(WIDTH)
) (
  input  logic [WIDTH-1:0]     rem,
  output logic [CNT_WIDTH-1:0] idx,
  output logic [WIDTH-1:0]     onehot,
  output logic                 single,
  output logic                 none
);

  // scan[] is rem re-ordered so that scan position i is the i-th bit visited;
  // in both modes the reported index then equals that scan position.
  logic [WIDTH-1:0] scan;
  logic [WIDTH-1:0] scan_oh;

  for (genvar g = 0; g < WIDTH; g++) begin : g_order
    if (MODE) begin : g_msb
      assign scan[g]             = rem[WIDTH-1-g];
      assign onehot[WIDTH-1-g]   = scan_oh[g];
    end else begin : g_lsb
      assign scan[g]   = rem[g];
      assign onehot[g] = scan_oh[g];
    end
  end

  assign scan_oh = scan & (~scan + WIDTH'(1));

  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (scan[i]) idx = CNT_WIDTH'(i);
    end
  end

  assign none   = (rem == '0);
  assign single = !none && ((rem & (rem - WIDTH'(1))) == '0);

endmodule

// File: rtl/gnrc_ffs_iter.sv
// Streaming set-bit iterator: accepts a vector and emits the index of every
// set bit, one beat per cycle, tagging the final beat of each vector.
module gnrc_ffs_iter
  import gnrc_ffs_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit MODE       = 1'b0,
  parameter bit EMIT_EMPTY = 1'b1,
  parameter int CNT_WIDTH  = ffs_cnt_width(WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [WIDTH-1:0]     vec_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [CNT_WIDTH-1:0] idx_o,
  output logic [CNT_WIDTH:0]   ord_o,
  output logic                 last_o,
  output logic                 empty_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 busy_o
);

  ffs_state_e           state_q, state_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [CNT_WIDTH:0]   ord_q, ord_d;
  logic                 empty_q, empty_d;

  logic [CNT_WIDTH-1:0] pick_idx;
  logic [WIDTH-1:0]     pick_oh;
  logic                 pick_single;
  logic                 pick_none;
  logic                 xfer;
  logic                 accept;

  gnrc_ffs_pick #(
    .WIDTH (WIDTH),
    .MODE  (MODE)
  ) u_pick (
    .rem    (rem_q),
    .idx    (pick_idx),
    .onehot (pick_oh),
    .single (pick_single),
    .none   (pick_none)
  );

  assign valid_o = (state_q == SCAN);
  assign busy_o  = (state_q == SCAN);
  assign idx_o   = (empty_q || pick_none) ? '0 : pick_idx;
  assign ord_o   = ord_q;
  assign empty_o = empty_q;
  assign last_o  = valid_o && (pick_single || empty_q);

  // ready_i feeds ready_o combinationally so a new vector can load on the
  // same edge that retires the last beat of the previous one.
  assign xfer    = valid_o && ready_i;
  assign ready_o = !flush_i && ((state_q == IDLE) || (xfer && last_o));
  assign accept  = valid_i && ready_o;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ord_d   = ord_q;
    empty_d = empty_q;

    if (xfer) begin
      rem_d = rem_q & ~pick_oh;
      ord_d = ord_q + (CNT_WIDTH+1)'(1);
      if (last_o) begin
        state_d = IDLE;
        rem_d   = '0;
        ord_d   = '0;
        empty_d = 1'b0;
      end
    end

    if (accept) begin
      ord_d   = '0;
      rem_d   = vec_i;
      empty_d = 1'b0;
      if (vec_i != '0) begin
        state_d = SCAN;
      end else if (EMIT_EMPTY) begin
        state_d = SCAN;
        empty_d = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end

    if (flush_i) begin
      state_d = IDLE;
      rem_d   = '0;
      ord_d   = '0;
      empty_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ord_q   <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ord_q   <= ord_d;
      empty_q <= empty_d;
    end
  end

endmodule

// File: tb/tb_gnrc_ffs_iter.sv
// Bench for gnrc_ffs_iter: three configurations share one stimulus stream and
// are checked every cycle against a beat-list model, plus directed scenarios.
module tb_gnrc_ffs_iter;

  localparam int NDUT = 3;
  localparam int W  [NDUT] = '{8, 8, 1};
  localparam int MD [NDUT] = '{0, 1, 0};
  localparam int EE [NDUT] = '{1, 0, 1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] vec = '0;
  logic       valid_i = 1'b0;
  logic       ready_i = 1'b0;

  logic [NDUT-1:0] o_ready, o_last, o_empty, o_valid, o_busy;
  logic [2:0] a_idx, b_idx;
  logic [0:0] c_idx;
  logic [3:0] a_ord, b_ord;
  logic [1:0] c_ord;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gnrc_ffs_iter #(.WIDTH(8), .MODE(1'b0), .EMIT_EMPTY(1'b1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .vec_i(vec), .valid_i(valid_i),
    .ready_o(o_ready[0]), .idx_o(a_idx), .ord_o(a_ord), .last_o(o_last[0]),
    .empty_o(o_empty[0]), .valid_o(o_valid[0]), .ready_i(ready_i), .busy_o(o_busy[0]));

  gnrc_ffs_iter #(.WIDTH(8), .MODE(1'b1), .EMIT_EMPTY(1'b0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .vec_i(vec), .valid_i(valid_i),
    .ready_o(o_ready[1]), .idx_o(b_idx), .ord_o(b_ord), .last_o(o_last[1]),
    .empty_o(o_empty[1]), .valid_o(o_valid[1]), .ready_i(ready_i), .busy_o(o_busy[1]));

  gnrc_ffs_iter #(.WIDTH(1), .MODE(1'b0), .EMIT_EMPTY(1'b1)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .vec_i(vec[0]), .valid_i(valid_i),
    .ready_o(o_ready[2]), .idx_o(c_idx), .ord_o(c_ord), .last_o(o_last[2]),
    .empty_o(o_empty[2]), .valid_o(o_valid[2]), .ready_i(ready_i), .busy_o(o_busy[2]));

  function automatic logic [31:0] get_idx(input int d);
    case (d)
      0: return 32'(a_idx);
      1: return 32'(b_idx);
      default: return 32'(c_idx);
    endcase
  endfunction

  function automatic logic [31:0] get_ord(input int d);
    case (d)
      0: return 32'(a_ord);
      1: return 32'(b_ord);
      default: return 32'(c_ord);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the list of beats still owed for the vector in flight, per DUT.
  typedef struct {
    int idx;
    int ord;
    bit last;
    bit empty;
  } beat_t;

  beat_t mb [NDUT][8];
  int    mh [NDUT] = '{0, 0, 0};
  int    mn [NDUT] = '{0, 0, 0};

  task automatic load(input int d, input logic [7:0] v);
    int pos[$];
    int n;
    int p;
    for (int b = 0; b < W[d]; b++) if (v[b]) pos.push_back(b);
    n = pos.size();
    mh[d] = 0;
    mn[d] = 0;
    if (n == 0) begin
      if (EE[d] != 0) begin
        mb[d][0] = '{idx: 0, ord: 0, last: 1'b1, empty: 1'b1};
        mn[d] = 1;
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        p = (MD[d] != 0) ? pos[n-1-k] : pos[k];
        mb[d][k] = '{idx: (MD[d] != 0) ? (W[d] - 1 - p) : p, ord: k,
                     last: (k == n - 1), empty: 1'b0};
      end
      mn[d] = n;
    end
  endtask

  function automatic bit exp_ready(input int d);
    return !flush && ((mn[d] == 0) || (ready_i && mb[d][mh[d]].last));
  endfunction

  always @(negedge rst_n) begin
    for (int d = 0; d < NDUT; d++) begin
      mn[d] = 0;
      mh[d] = 0;
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      bit rdy;
      bit xf;
      rdy = exp_ready(d);
      xf  = (mn[d] > 0) && ready_i;
      if (!rst_n) begin
        mn[d] = 0;
        mh[d] = 0;
      end else if (flush) begin
        mn[d] = 0;
        mh[d] = 0;
      end else begin
        if (xf) begin
          mh[d]++;
          mn[d]--;
        end
        if (valid_i && rdy) load(d, (d == 2) ? {7'b0, vec[0]} : vec);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < NDUT; d++) begin
        chk($sformatf("d%0d valid_o", d), 32'(o_valid[d]), 32'(mn[d] > 0));
        chk($sformatf("d%0d busy_o", d), 32'(o_busy[d]), 32'(mn[d] > 0));
        chk($sformatf("d%0d ready_o", d), 32'(o_ready[d]), 32'(exp_ready(d)));
        if (mn[d] > 0) begin
          chk($sformatf("d%0d idx_o", d), get_idx(d), 32'(mb[d][mh[d]].idx));
          chk($sformatf("d%0d ord_o", d), get_ord(d), 32'(mb[d][mh[d]].ord));
          chk($sformatf("d%0d last_o", d), 32'(o_last[d]), 32'(mb[d][mh[d]].last));
          chk($sformatf("d%0d empty_o", d), 32'(o_empty[d]), 32'(mb[d][mh[d]].empty));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("%s d%0d valid_o", tag, d), 32'(o_valid[d]), 0);
      chk($sformatf("%s d%0d busy_o", tag, d), 32'(o_busy[d]), 0);
      chk($sformatf("%s d%0d idx_o", tag, d), get_idx(d), 0);
      chk($sformatf("%s d%0d ord_o", tag, d), get_ord(d), 0);
      chk($sformatf("%s d%0d last_o", tag, d), 32'(o_last[d]), 0);
      chk($sformatf("%s d%0d empty_o", tag, d), 32'(o_empty[d]), 0);
    end
  endtask

  initial begin
    int exp_a[3];
    int exp_b[3];
    int r;

    // Reset state
    #2;
    chk_reset_vals("reset");
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("post-reset ready_o", 32'(o_ready[0]), 1);

    // 8'b1010_0100 in both scan orders
    exp_a = '{2, 5, 7};
    exp_b = '{0, 2, 5};
    step();
    vec = 8'b1010_0100; valid_i = 1'b1; ready_i = 1'b1;
    step();
    valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("lsb idx beat%0d", k), 32'(a_idx), 32'(exp_a[k]));
      chk($sformatf("lsb ord beat%0d", k), 32'(a_ord), 32'(k));
      chk($sformatf("lsb last beat%0d", k), 32'(o_last[0]), 32'(k == 2));
      chk($sformatf("msb idx beat%0d", k), 32'(b_idx), 32'(exp_b[k]));
      chk($sformatf("msb last beat%0d", k), 32'(o_last[1]), 32'(k == 2));
      if (k == 2) chk("ready_o on last beat", 32'(o_ready[0]), 1);
      step();
    end

    // 8'hFF with backpressure during beat ord=1
    vec = 8'hFF; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("ff idx0", 32'(a_idx), 0);
    step();
    ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall idx %0d", k), 32'(a_idx), 1);
      chk($sformatf("stall ord %0d", k), 32'(a_ord), 1);
      chk($sformatf("stall valid %0d", k), 32'(o_valid[0]), 1);
    end
    ready_i = 1'b1;
    for (int k = 2; k < 8; k++) begin
      step();
      chk($sformatf("resume idx %0d", k), 32'(a_idx), 32'(k));
    end
    step();

    // Back-to-back single-bit vectors with no bubble
    vec = 8'h01; valid_i = 1'b1;
    step();
    vec = 8'h80;
    chk("b2b first idx", 32'(a_idx), 0);
    chk("b2b first last", 32'(o_last[0]), 1);
    chk("b2b ready_o", 32'(o_ready[0]), 1);
    chk("b2b msb first idx", 32'(b_idx), 7);
    step();
    valid_i = 1'b0;
    chk("b2b second valid", 32'(o_valid[0]), 1);
    chk("b2b second idx", 32'(a_idx), 7);
    chk("b2b second last", 32'(o_last[0]), 1);
    chk("b2b msb second idx", 32'(b_idx), 0);
    step();

    // All-zero vector
    vec = 8'h00; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("zero emit valid", 32'(o_valid[0]), 1);
    chk("zero emit empty", 32'(o_empty[0]), 1);
    chk("zero emit idx", 32'(a_idx), 0);
    chk("zero emit last", 32'(o_last[0]), 1);
    chk("zero silent valid", 32'(o_valid[1]), 0);
    chk("zero silent ready", 32'(o_ready[1]), 1);
    step();

    // Flush after two beats, then a fresh vector
    vec = 8'hFF; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    step();
    step();
    flush = 1'b1;
    valid_i = 1'b1; vec = 8'h3C;
    chk("flush ready_o", 32'(o_ready[0]), 0);
    step();
    flush = 1'b0; valid_i = 1'b0;
    chk("flush valid_o", 32'(o_valid[0]), 0);
    chk("flush busy_o", 32'(o_busy[0]), 0);
    vec = 8'h10; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("after flush idx", 32'(a_idx), 4);
    chk("after flush last", 32'(o_last[0]), 1);
    chk("after flush msb idx", 32'(b_idx), 3);
    step();

    // Asynchronous reset in the middle of a scan
    vec = 8'hFF; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async reset");
    step();
    rst_n = 1'b1;
    #1;
    chk("after reset ready_o", 32'(o_ready[0]), 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      r = $urandom_range(0, 9);
      case (r)
        0: vec = 8'h00;
        1: vec = 8'(1 << $urandom_range(0, 7));
        2: vec = 8'hFF;
        default: vec = 8'($urandom);
      endcase
      valid_i = ($urandom_range(0, 9) < 7);
      ready_i = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 31) == 0);
    end
    step();
    valid_i = 1'b0; flush = 1'b0; ready_i = 1'b1;
    for (int i = 0; i < 12; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
